wb_data_mem: RTL and testbench
==============================

WB_DATA_MEM -- requirements
Module: wb_data_mem

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit words; power of two, at least 4.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, byte base address; aligned to DEPTH_WORDS*4.
REQ-003 Parameter WAIT_CYCLES, default 0, extra wait states per access; range 0-15.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 wb_adr_i  input  32  byte address from the wishbone_controller.
REQ-007 wb_dat_i  input  32  write data, already lane-aligned.
REQ-008 wb_sel_i  input  4  byte enables; bit n selects bits [8n+7:8n].
REQ-009 wb_we_i  input  1  1 = write, 0 = read.
REQ-010 wb_cyc_i  input  1  cycle valid.
REQ-011 wb_stb_i  input  1  strobe.
REQ-012 wb_dat_o  output  32  read data, registered.
REQ-013 wb_ack_o  output  1  normal termination, registered.
REQ-014 wb_err_o  output  1  error termination (address out of range), registered.

Function
REQ-015 Request = wb_cyc_i & wb_stb_i; the word index is wb_adr_i[log2(DEPTH_WORDS)+1:2]; wb_adr_i[1:0] is ignored.
REQ-016 In range = (wb_adr_i - BASE_ADDR) < DEPTH_WORDS*4, computed as a 32-bit unsigned subtraction; wrap-around below BASE_ADDR counts as out of range.
REQ-017 The FSM has states IDLE, WAIT, and RESP.
REQ-018 IDLE: on a request, go to WAIT and load the counter with WAIT_CYCLES-1 when WAIT_CYCLES>0; otherwise go directly to RESP.
REQ-019 WAIT: decrement the counter each cycle; at 0 with the request still present, go to RESP.
REQ-020 RESP: always return to IDLE after one cycle.
REQ-021 Entering RESP for an in-range request: wb_ack_o=1 for exactly that one cycle.
REQ-022 Entering RESP for an out-of-range request: wb_err_o=1 for exactly that one cycle, with no memory write and wb_dat_o unchanged.
REQ-023 The latency from request to ack is WAIT_CYCLES+1 cycles.
REQ-024 wb_ack_o and wb_err_o are never high together.
REQ-025 Write: on the edge entering RESP, update only the bytes whose wb_sel_i bit is 1; wb_sel_i=0000 completes with ack and changes nothing.
REQ-026 Read: on the edge entering RESP, load wb_dat_o with the full addressed word, ignoring wb_sel_i.
REQ-027 wb_dat_o holds its value until the next read ack, so the downstream load aligner can sample it one cycle after ack.
REQ-028 Write acks and error terminations leave wb_dat_o unchanged.
REQ-029 A request present in IDLE on the cycle right after RESP starts a new transaction; back-to-back accesses cost WAIT_CYCLES+2 cycles each.
REQ-030 Abort: if wb_cyc_i or wb_stb_i drops in WAIT, return to IDLE next cycle with no write, no ack, and no err.
REQ-031 Address, data, sel, and we are sampled on the edge entering RESP; the master holds them stable until ack or err.
REQ-032 Memory contents are undefined at power-up and are not cleared by rst.

Reset
REQ-033 While rst=1 at a clock edge: state=IDLE, counter=0, wb_ack_o=0, wb_err_o=0, wb_dat_o=32'h0.
REQ-034 rst asserted mid-transaction (WAIT or RESP) discards the transaction: no write, and ack/err are low on the next cycle.
REQ-035 rst has priority over any simultaneous request.

Structure
REQ-036 Package wb_pkg holds the FSM state typedef (wb_slv_state_t: IDLE, WAIT, RESP) and the WB_DATA_W=32 and WB_SEL_W=4 constants.
REQ-037 Sub-module sram_be: a synchronous single-port RAM with a per-byte write enable and a registered read port, parameterised by DEPTH_WORDS; the FSM, counter, and range check remain in wb_data_mem.

Verification
REQ-038 WAIT_CYCLES=0, write 32'hDEAD_BEEF to 0x10 with sel 1111, then read 0x10 -> each ack exactly 1 cycle after its request; read wb_dat_o=32'hDEAD_BEEF, held after ack.
REQ-039 Word 0x20 holds 32'h1122_3344; write 32'h00AA_0000 with sel 0100 -> a following read returns 32'h11AA_3344.
REQ-040 WAIT_CYCLES=3, read 0x04 -> ack on cycle 4 after the request asserts and low on cycles 1-3; back-to-back reads acked every 5 cycles.
REQ-041 DEPTH_WORDS=1024, BASE_ADDR=0, access 0x0000_1000 -> err_o pulses 1 cycle, ack_o stays 0, memory and wb_dat_o unchanged.
REQ-042 WAIT_CYCLES=3, write dropping wb_stb_i after 1 cycle -> no ack or err; a subsequent read shows the old data.
REQ-043 WAIT_CYCLES=2, rst pulsed during WAIT of a write -> outputs zero next cycle, the target word is unmodified, and the next request completes normally.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg -- shared definitions for the Wishbone data-memory slave.
//   WB_DATA_W      : Wishbone data bus width (bits)
//   WB_SEL_W       : number of byte-select lanes
//   wb_slv_state_t : slave FSM state (IDLE, WAIT, RESP)
package wb_pkg;

   localparam int WB_DATA_W = 32;
   localparam int WB_SEL_W  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } wb_slv_state_t;

endpackage

// File: rtl/sram_be.sv
// sram_be -- synchronous single-port RAM with per-byte write enables and a
// registered read port. Contents are not reset; only the read register is.
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset of the read register only
//   addr   : word index
//   we     : write strobe, combined with be per byte lane
//   be     : byte enables, bit n covers wdata[8n+7:8n]
//   wdata  : write data
//   re     : read strobe; rdata loads mem[addr] on the edge and holds otherwise
//   rdata  : registered read data
module sram_be
   import wb_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024
)
(
   input  logic                           clk,
   input  logic                           rst,
   input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
   input  logic                           we,
   input  logic [WB_SEL_W-1:0]            be,
   input  logic [WB_DATA_W-1:0]           wdata,
   input  logic                           re,
   output logic [WB_DATA_W-1:0]           rdata
);

   logic [WB_DATA_W-1:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < WB_SEL_W; b++) begin
            if (be[b]) begin
               mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

   // Read register only updates on a read strobe so the last read word
   // stays visible to the consumer until the next read.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/wb_data_mem.sv
// wb_data_mem -- Wishbone classic slave in front of a byte-writable RAM,
// with a configurable number of wait states and an address range check.
// Parameters:
//   DEPTH_WORDS : number of 32-bit words (power of two, >= 4)
//   BASE_ADDR   : byte base address, aligned to DEPTH_WORDS*4
//   WAIT_CYCLES : extra wait states per access (0..15)
// Ports:
//   clk, rst            : clock and synchronous active-high reset
//   wb_adr_i            : byte address
//   wb_dat_i            : lane-aligned write data
//   wb_sel_i            : byte enables
//   wb_we_i             : 1 = write, 0 = read
//   wb_cyc_i, wb_stb_i  : cycle / strobe
//   wb_dat_o            : registered read data, held until the next read ack
//   wb_ack_o            : registered normal termination pulse
//   wb_err_o            : registered error pulse (address out of range)
module wb_data_mem
   import wb_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_CYCLES = 0
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          wb_adr_i,
   input  logic [WB_DATA_W-1:0] wb_dat_i,
   input  logic [WB_SEL_W-1:0]  wb_sel_i,
   input  logic                 wb_we_i,
   input  logic                 wb_cyc_i,
   input  logic                 wb_stb_i,
   output logic [WB_DATA_W-1:0] wb_dat_o,
   output logic                 wb_ack_o,
   output logic                 wb_err_o
);

   localparam int          ADDR_W     = $clog2(DEPTH_WORDS);
   localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 4);
   // WAIT is entered with WAIT_CYCLES-1 and left when the counter reads 0,
   // giving WAIT_CYCLES cycles in WAIT before RESP.
   localparam logic [3:0]  CNT_LOAD   = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   wb_slv_state_t state, state_nxt;
   logic [3:0]    cnt, cnt_nxt;
   logic          req;
   logic [31:0]   offset;
   logic          in_range;
   logic          enter_resp;
   logic          mem_we;
   logic          mem_re;

   assign req = wb_cyc_i & wb_stb_i;

   // Unsigned subtraction: addresses below BASE_ADDR wrap to large offsets
   // and therefore fail the comparison.
   assign offset   = wb_adr_i - BASE_ADDR;
   assign in_range = (offset < SPAN_BYTES);

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      enter_resp = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               if (WAIT_CYCLES > 0) begin
                  state_nxt = WAIT;
                  cnt_nxt   = CNT_LOAD;
               end else begin
                  state_nxt  = RESP;
                  enter_resp = 1'b1;
               end
            end
         end
         WAIT: begin
            if (!req) begin
               // Master abandoned the access: nothing is written or acked.
               state_nxt = IDLE;
               cnt_nxt   = 4'd0;
            end else if (cnt == 4'd0) begin
               state_nxt  = RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         RESP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
         end
      endcase
   end

   // Memory side effects happen on the same edge that enters RESP; reset
   // wins over a request arriving on that edge.
   assign mem_we = enter_resp & in_range &  wb_we_i & ~rst;
   assign mem_re = enter_resp & in_range & ~wb_we_i & ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         wb_ack_o <= 1'b0;
         wb_err_o <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         wb_ack_o <= enter_resp &  in_range;
         wb_err_o <= enter_resp & ~in_range;
      end
   end

   // BASE_ADDR is aligned to the memory span, so the low address bits index
   // the array directly without subtracting the base.
   sram_be #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_sram (
      .clk   (clk),
      .rst   (rst),
      .addr  (wb_adr_i[ADDR_W+1:2]),
      .we    (mem_we),
      .be    (wb_sel_i),
      .wdata (wb_dat_i),
      .re    (mem_re),
      .rdata (wb_dat_o)
   );

endmodule

// File: tb/tb_wb_data_mem.sv
// tb_wb_data_mem -- self-checking bench for wb_data_mem. Three instances
// with WAIT_CYCLES of 0, 3 and 2 share the address/data/sel/we bus but have
// private cyc/stb/rst, so only one instance is addressed at a time.
module tb_wb_data_mem;

   localparam int          DEPTH = 1024;
   localparam logic [31:0] BASE  = 32'h0000_0000;
   localparam int          WC [3] = '{0, 3, 2};

   logic        clk = 1'b0;
   logic        rst  [3];
   logic        cyc  [3];
   logic        stb  [3];
   logic [31:0] adr;
   logic [31:0] wdat;
   logic [3:0]  sel;
   logic        we;
   logic [31:0] dato [3];
   logic        ack  [3];
   logic        err  [3];

   always #5 clk = ~clk;

   wb_data_mem #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst[0]), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
      .wb_we_i(we), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]),
      .wb_dat_o(dato[0]), .wb_ack_o(ack[0]), .wb_err_o(err[0]));

   wb_data_mem #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(3)) dut1 (
      .clk(clk), .rst(rst[1]), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
      .wb_we_i(we), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]),
      .wb_dat_o(dato[1]), .wb_ack_o(ack[1]), .wb_err_o(err[1]));

   wb_data_mem #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(2)) dut2 (
      .clk(clk), .rst(rst[2]), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
      .wb_we_i(we), .wb_cyc_i(cyc[2]), .wb_stb_i(stb[2]),
      .wb_dat_o(dato[2]), .wb_ack_o(ack[2]), .wb_err_o(err[2]));

   // Reference model: word array per instance plus the expected read register.
   logic [31:0] mref    [3][DEPTH];
   logic [31:0] exp_dat [3];
   int checks;
   int errors;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit in_rng(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return off < 32'(DEPTH * 4);
   endfunction

   function automatic int widx(input logic [31:0] a);
      logic [31:0] off;
      off = (a - BASE) >> 2;
      return int'(off);
   endfunction

   // One complete access with the master dropping the request on ack/err.
   task automatic access(input int k, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
      int n;
      bit done;
      bit ir;
      int idx;
      ir   = in_rng(a);
      idx  = ir ? widx(a) : 0;
      we   = w;
      adr  = a;
      wdat = d;
      sel  = s;
      cyc[k] = 1'b1;
      stb[k] = 1'b1;
      n    = 0;
      done = 1'b0;
      while (!done && n < 40) begin
         @(posedge clk); #1;
         n++;
         if (ack[k] || err[k]) done = 1'b1;
      end
      chk("latency", 32'(n), 32'(WC[k] + 1));
      chk("ack", 32'(ack[k]), 32'(ir));
      chk("err", 32'(err[k]), 32'(!ir));
      chk("ack_err_excl", 32'(ack[k] & err[k]), 32'd0);
      cyc[k] = 1'b0;
      stb[k] = 1'b0;
      if (ir) begin
         if (w) begin
            for (int b = 0; b < 4; b++)
               if (s[b]) mref[k][idx][8*b +: 8] = d[8*b +: 8];
         end else begin
            exp_dat[k] = mref[k][idx];
         end
      end
      chk("dat_o", dato[k], exp_dat[k]);
      @(posedge clk); #1;
      chk("ack_low", 32'(ack[k]), 32'd0);
      chk("err_low", 32'(err[k]), 32'd0);
      chk("dat_hold", dato[k], exp_dat[k]);
   endtask

   // Request held high continuously: three acks, WC+2 cycles apart.
   task automatic b2b(input int k, input logic [31:0] a);
      int p;
      bit e;
      p    = WC[k] + 2;
      we   = 1'b0;
      adr  = a;
      sel  = 4'hF;
      cyc[k] = 1'b1;
      stb[k] = 1'b1;
      for (int c = 1; c <= 3 * p - 1; c++) begin
         @(posedge clk); #1;
         e = ((c % p) == (p - 1));
         chk("b2b_ack", 32'(ack[k]), 32'(e));
         chk("b2b_err", 32'(err[k]), 32'd0);
         if (e) chk("b2b_dat", dato[k], mref[k][widx(a)]);
      end
      cyc[k] = 1'b0;
      stb[k] = 1'b0;
      exp_dat[k] = mref[k][widx(a)];
      @(posedge clk); #1;
      chk("b2b_end_ack", 32'(ack[k]), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      int r;
      checks = 0;
      errors = 0;
      adr  = '0;
      wdat = '0;
      sel  = '0;
      we   = 1'b0;
      for (int k = 0; k < 3; k++) begin
         rst[k] = 1'b1;
         cyc[k] = 1'b0;
         stb[k] = 1'b0;
         exp_dat[k] = 32'h0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("rst_ack", 32'(ack[k]), 32'd0);
         chk("rst_err", 32'(err[k]), 32'd0);
         chk("rst_dat", dato[k], 32'h0);
         rst[k] = 1'b0;
      end
      @(posedge clk); #1;

      // Zero-wait write then read of the same word.
      access(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
      access(0, 1'b0, 32'h10, 32'h0, 4'hF);
      chk("rd_deadbeef", dato[0], 32'hDEAD_BEEF);

      // Single byte lane update, then an all-lanes-off write.
      access(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF);
      access(0, 1'b1, 32'h20, 32'h00AA_0000, 4'b0100);
      access(0, 1'b0, 32'h20, 32'h0, 4'h0);
      chk("byte_merge", dato[0], 32'h11AA_3344);
      access(0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000);
      access(0, 1'b0, 32'h20, 32'h0, 4'hF);
      chk("sel_zero", dato[0], 32'h11AA_3344);

      // Out-of-range accesses; 0x1000 aliases word 0 in the index bits.
      access(0, 1'b1, 32'h0, 32'h0102_0304, 4'hF);
      access(0, 1'b0, 32'h10, 32'h0, 4'hF);
      access(0, 1'b1, 32'h1000, 32'hBADB_AD00, 4'hF);
      access(0, 1'b0, 32'h1000, 32'h0, 4'hF);
      chk("err_dat_keep", dato[0], 32'hDEAD_BEEF);
      access(0, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF);
      access(0, 1'b0, 32'h0, 32'h0, 4'hF);
      chk("err_no_write", dato[0], 32'h0102_0304);

      // Back-to-back reads on every instance.
      for (int k = 0; k < 3; k++) begin
         access(k, 1'b1, 32'h4, 32'hA5A5_0000 + 32'(k), 4'hF);
         b2b(k, 32'h4);
      end

      // Abort in WAIT: strobe dropped one cycle into a write.
      access(1, 1'b1, 32'h8, 32'h5566_7788, 4'hF);
      we   = 1'b1;
      adr  = 32'h8;
      wdat = 32'h9999_9999;
      sel  = 4'hF;
      cyc[1] = 1'b1;
      stb[1] = 1'b1;
      @(posedge clk); #1;
      stb[1] = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         chk("abort_ack", 32'(ack[1]), 32'd0);
         chk("abort_err", 32'(err[1]), 32'd0);
      end
      cyc[1] = 1'b0;
      access(1, 1'b0, 32'h8, 32'h0, 4'hF);
      chk("abort_old", dato[1], 32'h5566_7788);

      // Reset during WAIT of a write.
      access(2, 1'b1, 32'h40, 32'hCAFE_0001, 4'hF);
      access(2, 1'b0, 32'h40, 32'h0, 4'hF);
      we   = 1'b1;
      adr  = 32'h40;
      wdat = 32'h0BAD_0BAD;
      sel  = 4'hF;
      cyc[2] = 1'b1;
      stb[2] = 1'b1;
      @(posedge clk); #1;
      rst[2] = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_ack", 32'(ack[2]), 32'd0);
      chk("mid_rst_err", 32'(err[2]), 32'd0);
      chk("mid_rst_dat", dato[2], 32'h0);
      rst[2] = 1'b0;
      cyc[2] = 1'b0;
      stb[2] = 1'b0;
      exp_dat[2] = 32'h0;
      @(posedge clk); #1;
      chk("post_rst_ack", 32'(ack[2]), 32'd0);
      access(2, 1'b0, 32'h40, 32'h0, 4'hF);
      chk("rst_no_write", dato[2], 32'hCAFE_0001);

      // Randomized traffic over a 16-word window plus out-of-range addresses.
      for (int k = 0; k < 3; k++) begin
         for (int w = 0; w < 16; w++)
            access(k, 1'b1, 32'(w) * 4, $urandom, 4'hF);
         for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)      a = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
            else if (r == 1) a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else             a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
            access(k, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
